mem_port_arbiter: RTL and testbench

- Shares unified-memory data port A between the pipeline's Memory-stage load/store (core) and a debug/program-loader requester (dbg).
- Core has priority. Dbg is served in cycles where the core has no memory op.
- A starvation counter forces a one-cycle full-pipeline hold so dbg always progresses.
- Sits between the M-stage control/ALU signals and the unified memory, and drives the hazard unit's stall input.

---
 rtl/mem_port_arbiter_if.sv | 76 +++++++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Port-A sharing bundle: M-stage core access, debug/loader requester and unified-memory port.
// slave is the arbiter's view; master is the surrounding pipeline/memory/debug view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 12
);

   // Core (M stage)
   logic              Core_Req;
   logic              Core_W_En;
   logic [2:0]        Core_Control;
   logic [ADDR_W-1:0] Core_Addr;
   logic [31:0]       Core_WData;

   // Debug / program loader
   logic              Dbg_Valid;
   logic              Dbg_Ready;
   logic              Dbg_W_En;
   logic [2:0]        Dbg_Control;
   logic [ADDR_W-1:0] Dbg_Addr;
   logic [31:0]       Dbg_WData;
   logic              Dbg_RValid;
   logic [31:0]       Dbg_RData;

   // Unified memory port A and hazard unit
   logic [31:0]       Mem_R_Data;
   logic              MEM_W_En;
   logic [2:0]        MEM_Control;
   logic [ADDR_W-1:0] RW_Addr;
   logic [31:0]       W_Data;
   logic              Core_Hold;

   modport slave (
      input  Core_Req,
      input  Core_W_En,
      input  Core_Control,
      input  Core_Addr,
      input  Core_WData,
      input  Dbg_Valid,
      output Dbg_Ready,
      input  Dbg_W_En,
      input  Dbg_Control,
      input  Dbg_Addr,
      input  Dbg_WData,
      output Dbg_RValid,
      output Dbg_RData,
      input  Mem_R_Data,
      output MEM_W_En,
      output MEM_Control,
      output RW_Addr,
      output W_Data,
      output Core_Hold
   );

   modport master (
      output Core_Req,
      output Core_W_En,
      output Core_Control,
      output Core_Addr,
      output Core_WData,
      output Dbg_Valid,
      input  Dbg_Ready,
      output Dbg_W_En,
      output Dbg_Control,
      output Dbg_Addr,
      output Dbg_WData,
      input  Dbg_RValid,
      input  Dbg_RData,
      output Mem_R_Data,
      input  MEM_W_En,
      input  MEM_Control,
      input  RW_Addr,
      input  W_Data,
      input  Core_Hold
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates unified-memory port A between the M-stage core (priority) and a debug requester,
// forcing a pipeline hold after MAX_WAIT blocked cycles. Define MEM_ARB_BURST_EN for burst holds.
module mem_port_arbiter #(
   parameter int unsigned MAX_WAIT  = 8,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned ADDR_W    = 12
) (
   input logic               CLK,
   input logic               RST,
   mem_port_arbiter_if.slave bus_io
);

   typedef enum logic [0:0] {StCore, StHold} state_e;

   localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

   if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
      $error("mem_port_arbiter: MAX_WAIT must be in 1..255");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
      $error("mem_port_arbiter: MAX_BURST must be in 1..255");
   end

   state_e            state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              rvalid_q, rvalid_d;
   logic              core_grant;
   logic              dbg_grant;
   logic [ADDR_W-1:0] addr_mux;

`ifdef MEM_ARB_BURST_EN
   localparam logic [7:0] MaxBurstC = 8'(MAX_BURST);
   logic [7:0] beat_cnt_q, beat_cnt_d;
`endif

   // Core always wins outside a hold; dbg takes any cycle the core leaves free.
   always_comb begin
      core_grant = (state_q == StCore) && bus_io.Core_Req;
      dbg_grant  = bus_io.Dbg_Valid && !core_grant;
   end

   always_comb begin
      bus_io.MEM_W_En    = 1'b0;
      bus_io.MEM_Control = bus_io.Core_Control;
      addr_mux           = bus_io.Core_Addr;
      bus_io.W_Data      = bus_io.Core_WData;
      if (core_grant) begin
         bus_io.MEM_W_En = bus_io.Core_W_En;
      end else if (dbg_grant) begin
         bus_io.MEM_W_En    = bus_io.Dbg_W_En;
         bus_io.MEM_Control = bus_io.Dbg_Control;
         addr_mux           = bus_io.Dbg_Addr;
         bus_io.W_Data      = bus_io.Dbg_WData;
      end
   end

   assign bus_io.RW_Addr    = addr_mux;
   assign bus_io.Dbg_Ready  = dbg_grant;
   assign bus_io.Core_Hold  = (state_q == StHold);
   assign bus_io.Dbg_RValid = rvalid_q;
   assign bus_io.Dbg_RData  = rvalid_q ? bus_io.Mem_R_Data : 32'h0;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = 8'h0;
      rvalid_d   = dbg_grant && !bus_io.Dbg_W_En;
`ifdef MEM_ARB_BURST_EN
      beat_cnt_d = beat_cnt_q;
`endif
      if (bus_io.Dbg_Valid && !dbg_grant) begin
         wait_cnt_d = (wait_cnt_q >= MaxWaitC) ? MaxWaitC : wait_cnt_q + 8'd1;
      end

      unique case (state_q)
         StCore: begin
            if (wait_cnt_d == MaxWaitC) begin
               state_d = StHold;
`ifdef MEM_ARB_BURST_EN
               beat_cnt_d = 8'h0;
`endif
            end
         end
         StHold: begin
`ifdef MEM_ARB_BURST_EN
            beat_cnt_d = beat_cnt_q + 8'(dbg_grant);
            if (!bus_io.Dbg_Valid || beat_cnt_d >= MaxBurstC) begin
               state_d = StCore;
            end
`else
            state_d = StCore;
`endif
         end
         default: state_d = StCore;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StCore;
         wait_cnt_q <= 8'h0;
         rvalid_q   <= 1'b0;
`ifdef MEM_ARB_BURST_EN
         beat_cnt_q <= 8'h0;
`endif
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rvalid_q   <= rvalid_d;
`ifdef MEM_ARB_BURST_EN
         beat_cnt_q <= beat_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level
// reference model of the arbitration rules and a byte-array memory.
module tb_mem_port_arbiter;

   localparam int unsigned MAX_WAIT  = 8;
   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

   // Memory control encoding used by the bench memory: [1:0] byte/half/word, [2] unsigned.
   localparam logic [2:0] CtlByteS = 3'b000;
   localparam logic [2:0] CtlHalfS = 3'b001;
   localparam logic [2:0] CtlWord  = 3'b010;
   localparam logic [2:0] CtlByteU = 3'b100;
   localparam logic [2:0] CtlHalfU = 3'b101;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(
      .MAX_WAIT (MAX_WAIT),
      .MAX_BURST(MAX_BURST),
      .ADDR_W   (ADDR_W)
   ) dut (
      .CLK   (clk),
      .RST   (rst),
      .bus_io(bus)
   );

   function automatic int size_bytes(input logic [2:0] ctl);
      case (ctl[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] ctl);
      case (ctl[1:0])
         2'b00:   return ctl[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
         2'b01:   return ctl[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Environment memory: writes at the edge, read data from the registered address/control.
   logic [7:0]        env_mem [MEM_DEPTH];
   logic [ADDR_W-1:0] env_raddr = '0;
   logic [2:0]        env_rctl  = '0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) env_mem[i] <= 8'h0;
      end else if (bus.MEM_W_En) begin
         for (int i = 0; i < 4; i++) begin
            if (i < size_bytes(bus.MEM_Control))
               env_mem[ADDR_W'(bus.RW_Addr + ADDR_W'(i))] <= bus.W_Data[8*i +: 8];
         end
      end
      env_raddr <= bus.RW_Addr;
      env_rctl  <= bus.MEM_Control;
   end

   always_comb begin
      bus.Mem_R_Data = extend({env_mem[ADDR_W'(env_raddr + ADDR_W'(3))],
                               env_mem[ADDR_W'(env_raddr + ADDR_W'(2))],
                               env_mem[ADDR_W'(env_raddr + ADDR_W'(1))],
                               env_mem[env_raddr]}, env_rctl);
   end

   // Reference model state
   logic [7:0]  ref_mem [MEM_DEPTH];
   int          m_blocked = 0;
   bit          m_hold    = 1'b0;
   int          m_beats   = 0;
   bit          m_rd_pend = 1'b0;
   logic [31:0] m_rd_data = '0;
   bit          m_dbg_g   = 1'b0;

   function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a, input logic [2:0] ctl);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[ADDR_W'(a + ADDR_W'(i))];
      return extend(w, ctl);
   endfunction

   function automatic void ref_write(input logic [ADDR_W-1:0] a, input logic [2:0] ctl,
                                     input logic [31:0] d);
      for (int i = 0; i < size_bytes(ctl); i++) ref_mem[ADDR_W'(a + ADDR_W'(i))] = d[8*i +: 8];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Compare every output against the model at the falling edge, then advance the model.
   task automatic chk_cycle();
      bit hold, core_g, dbg_g;
      @(negedge clk);
      hold   = m_hold;
      core_g = !hold && bus.Core_Req;
      dbg_g  = bus.Dbg_Valid && !core_g;
      if (!rst) begin
         check_eq("dbg_ready", bus.Dbg_Ready, dbg_g);
         check_eq("core_hold", bus.Core_Hold, hold);
         check_eq("mem_w_en", bus.MEM_W_En,
                  core_g ? bus.Core_W_En : (dbg_g && bus.Dbg_W_En));
         check_eq("rw_addr", bus.RW_Addr, dbg_g ? bus.Dbg_Addr : bus.Core_Addr);
         check_eq("mem_ctl", bus.MEM_Control, dbg_g ? bus.Dbg_Control : bus.Core_Control);
         check_eq("w_data", bus.W_Data, dbg_g ? bus.Dbg_WData : bus.Core_WData);
         check_eq("dbg_rvalid", bus.Dbg_RValid, m_rd_pend);
         check_eq("dbg_rdata", bus.Dbg_RData, m_rd_pend ? m_rd_data : 32'h0);
      end
      m_dbg_g = dbg_g;
      if (rst) begin
         m_blocked = 0;
         m_hold    = 1'b0;
         m_beats   = 0;
         m_rd_pend = 1'b0;
         for (int i = 0; i < int'(MEM_DEPTH); i++) ref_mem[i] = 8'h0;
      end else begin
         if (core_g && bus.Core_W_En) ref_write(bus.Core_Addr, bus.Core_Control, bus.Core_WData);
         if (dbg_g && bus.Dbg_W_En) ref_write(bus.Dbg_Addr, bus.Dbg_Control, bus.Dbg_WData);
         m_rd_pend = dbg_g && !bus.Dbg_W_En;
         if (m_rd_pend) m_rd_data = ref_read(bus.Dbg_Addr, bus.Dbg_Control);
         if (bus.Dbg_Valid && !dbg_g) m_blocked = (m_blocked < int'(MAX_WAIT)) ? m_blocked + 1
                                                                               : int'(MAX_WAIT);
         else m_blocked = 0;
`ifdef MEM_ARB_BURST_EN
         if (hold) begin
            m_beats = m_beats + int'(dbg_g);
            m_hold  = bus.Dbg_Valid && (m_beats < int'(MAX_BURST));
         end else begin
            m_beats = 0;
            m_hold  = (m_blocked == int'(MAX_WAIT));
         end
`else
         m_hold = !hold && (m_blocked == int'(MAX_WAIT));
`endif
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input bit req, input bit we, input logic [2:0] ctl,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
      bus.Core_Req     = req;
      bus.Core_W_En    = we;
      bus.Core_Control = ctl;
      bus.Core_Addr    = addr;
      bus.Core_WData   = wd;
   endtask

   task automatic set_dbg(input bit vld, input bit we, input logic [2:0] ctl,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
      bus.Dbg_Valid   = vld;
      bus.Dbg_W_En    = we;
      bus.Dbg_Control = ctl;
      bus.Dbg_Addr    = addr;
      bus.Dbg_WData   = wd;
   endtask

   task automatic rand_access(output logic [2:0] ctl, output logic [ADDR_W-1:0] addr);
      logic [2:0] ctls [5];
      ctls = '{CtlByteS, CtlHalfS, CtlWord, CtlByteU, CtlHalfU};
      ctl  = ctls[$urandom_range(0, 4)];
      addr = ADDR_W'($urandom_range(0, 63) & ~(size_bytes(ctl) - 1));
   endtask

   initial begin
      logic [2:0]        ctl;
      logic [ADDR_W-1:0] addr;
      bit                dbg_busy;

      rst = 1'b1;
      set_core(1'b0, 1'b0, CtlWord, '0, '0);
      set_dbg(1'b0, 1'b0, CtlWord, '0, '0);
      chk_cycle();
      check_eq("rst_core_hold", bus.Core_Hold, 1'b0);
      check_eq("rst_dbg_ready", bus.Dbg_Ready, 1'b0);
      check_eq("rst_mem_w_en", bus.MEM_W_En, 1'b0);
      check_eq("rst_dbg_rvalid", bus.Dbg_RValid, 1'b0);
      adv();
      rst = 1'b0;

      // Core idle: dbg word write goes straight through.
      set_dbg(1'b1, 1'b1, CtlWord, 12'h010, 32'hDEADBEEF);
      chk_cycle();
      check_eq("wr_ready", bus.Dbg_Ready, 1'b1);
      check_eq("wr_w_en", bus.MEM_W_En, 1'b1);
      check_eq("wr_addr", bus.RW_Addr, 12'h010);
      check_eq("wr_no_hold", bus.Core_Hold, 1'b0);
      adv();

      // Byte-unsigned read of the top byte of that word.
      set_dbg(1'b1, 1'b0, CtlByteU, 12'h013, 32'h0);
      chk_cycle();
      check_eq("rd_ready", bus.Dbg_Ready, 1'b1);
      adv();
      set_dbg(1'b0, 1'b0, CtlWord, '0, '0);
      chk_cycle();
      check_eq("rd_rvalid", bus.Dbg_RValid, 1'b1);
      check_eq("rd_rdata", bus.Dbg_RData, 32'h000000DE);
      adv();

`ifndef MEM_ARB_BURST_EN
      // Continuous core traffic: 8 blocked cycles, hold on the 9th, core again on the 10th.
      set_core(1'b1, 1'b0, CtlWord, 12'h100, 32'h0);
      set_dbg(1'b1, 1'b0, CtlWord, 12'h010, 32'h0);
      for (int i = 0; i < int'(MAX_WAIT); i++) begin
         chk_cycle();
         check_eq("starve_blocked", bus.Dbg_Ready, 1'b0);
         adv();
      end
      chk_cycle();
      check_eq("starve_hold", bus.Core_Hold, 1'b1);
      check_eq("starve_grant", bus.Dbg_Ready, 1'b1);
      adv();
      set_dbg(1'b0, 1'b0, CtlWord, '0, '0);
      chk_cycle();
      check_eq("after_hold", bus.Core_Hold, 1'b0);
      check_eq("after_hold_addr", bus.RW_Addr, 12'h100);
      check_eq("after_hold_rdata", bus.Dbg_RData, 32'hDEADBEEF);
      adv();

      // Core store against a fresh dbg request; the wait count restarts from one.
      set_core(1'b1, 1'b1, CtlWord, 12'h020, 32'h12345678);
      set_dbg(1'b1, 1'b0, CtlByteU, 12'h013, 32'h0);
      chk_cycle();
      check_eq("store_w_en", bus.MEM_W_En, 1'b1);
      check_eq("store_addr", bus.RW_Addr, 12'h020);
      check_eq("store_no_ready", bus.Dbg_Ready, 1'b0);
      adv();
      set_core(1'b1, 1'b0, CtlWord, 12'h100, 32'h0);
      for (int i = 1; i < int'(MAX_WAIT); i++) begin
         chk_cycle();
         check_eq("store_wait_no_hold", bus.Core_Hold, 1'b0);
         adv();
      end

      // Reset landing on the hold cycle drops the hold and the pending read response.
      rst = 1'b1;
      chk_cycle();
      check_eq("rst_in_hold", bus.Core_Hold, 1'b1);
      adv();
      rst = 1'b0;
      set_core(1'b0, 1'b0, CtlWord, '0, '0);
      set_dbg(1'b0, 1'b0, CtlWord, '0, '0);
      chk_cycle();
      check_eq("post_rst_hold", bus.Core_Hold, 1'b0);
      check_eq("post_rst_rvalid", bus.Dbg_RValid, 1'b0);
      adv();
`else
      // Burst: 8 blocked, 4 held beats, one core cycle, then core idles to finish 6 beats.
      set_core(1'b1, 1'b0, CtlWord, 12'h100, 32'h0);
      set_dbg(1'b1, 1'b0, CtlWord, 12'h010, 32'h0);
      for (int c = 1; c <= int'(MAX_WAIT) + int'(MAX_BURST) + 1; c++) begin
         chk_cycle();
         if (c <= int'(MAX_WAIT)) begin
            check_eq("burst_blocked", bus.Dbg_Ready, 1'b0);
         end else if (c <= int'(MAX_WAIT + MAX_BURST)) begin
            check_eq("burst_hold", bus.Core_Hold, 1'b1);
            check_eq("burst_grant", bus.Dbg_Ready, 1'b1);
         end else begin
            check_eq("burst_exit_hold", bus.Core_Hold, 1'b0);
            check_eq("burst_exit_ready", bus.Dbg_Ready, 1'b0);
         end
         adv();
      end
      set_core(1'b0, 1'b0, CtlWord, '0, '0);
      for (int c = 0; c < 2; c++) begin
         chk_cycle();
         check_eq("burst_tail", bus.Dbg_Ready, 1'b1);
         adv();
      end
      set_dbg(1'b0, 1'b0, CtlWord, '0, '0);
      chk_cycle();
      adv();
`endif

      // Randomized traffic: heavy then light core load, occasional reset.
      dbg_busy = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 599) == 0);
         rand_access(ctl, addr);
         set_core($urandom_range(0, 99) < ((c < 2000) ? 85 : 35), 1'($urandom_range(0, 1)),
                  ctl, addr, $urandom);
         if (!dbg_busy) begin
            rand_access(ctl, addr);
            if ($urandom_range(0, 99) < 60) begin
               set_dbg(1'b1, 1'($urandom_range(0, 1)), ctl, addr, $urandom);
               dbg_busy = 1'b1;
            end else begin
               set_dbg(1'b0, 1'($urandom_range(0, 1)), ctl, addr, $urandom);
            end
         end
         chk_cycle();
         if (m_dbg_g || rst) dbg_busy = 1'b0;
         adv();
      end

      rst = 1'b0;
      set_core(1'b0, 1'b0, CtlWord, '0, '0);
      set_dbg(1'b0, 1'b0, CtlWord, '0, '0);
      chk_cycle();
      adv();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
